// File: rtl/axi_sram_read_responder.sv
// ---------------------------------------------------------------------------
// axi_sram_read_responder
//
// Purpose:
//   AXI read-channel slave that sits between an interconnect slave port and a
//   single-port synchronous SRAM. One AR transaction is accepted at a time.
//   Each beat of the burst is read from the SRAM and returned on the R channel
//   with the ID echoed, RLAST on the final beat and full RREADY backpressure.
//   Requests that cannot be served still return ARLEN+1 beats, each marked
//   SLVERR, and never touch the SRAM.
//
// Optional feature:
//   AXI_WRAP_BURST_EN - when defined, WRAP bursts with ARLEN of 1, 3, 7 or 15
//                       are served. When undefined, every WRAP request is
//                       answered with SLVERR beats.
//
// Ports:
//   ACLK, ARESETn      clock, asynchronous active-low reset
//   AR*_S              read address channel (ID, byte address, len, size,
//                      burst, valid/ready)
//   R*_S               read data channel (ID, data, resp, last, valid/ready)
//   mem_cs, mem_addr   SRAM chip select and word address (registered)
//   mem_rdata          SRAM read data, valid the cycle after mem_cs
// ---------------------------------------------------------------------------
module axi_sram_read_responder #(
    parameter int MEM_AW = 14,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic [7:0]        ARID_S,
    input  logic [31:0]       ARADDR_S,
    input  logic [3:0]        ARLEN_S,
    input  logic [2:0]        ARSIZE_S,
    input  logic [1:0]        ARBURST_S,
    input  logic              ARVALID_S,
    output logic              ARREADY_S,

    output logic [7:0]        RID_S,
    output logic [DATA_W-1:0] RDATA_S,
    output logic [1:0]        RRESP_S,
    output logic              RLAST_S,
    output logic              RVALID_S,
    input  logic              RREADY_S,

    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q;
    logic                arready_q;
    logic [7:0]          rid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic                rlast_q;
    logic                rvalid_q;
    logic                mem_cs_q;
    logic [MEM_AW-1:0]   mem_addr_q;

    logic [31:0]         cur_addr_q;
    logic [31:0]         cur_addr_d;
    logic [3:0]          len_q;
    logic [1:0]          burst_q;
    logic [3:0]          beat_cnt_q;
    logic                err_q;
    logic                req_err_d;

    // -----------------------------------------------------------------------
    // Request legality: only 4-byte beats, no reserved burst type, and WRAP
    // only when the feature is built in and the length is a power of two.
    // -----------------------------------------------------------------------
    always_comb begin
        req_err_d = 1'b0;
        if (ARSIZE_S != SIZE_4B) begin
            req_err_d = 1'b1;
        end
        if (ARBURST_S == BURST_RSVD) begin
            req_err_d = 1'b1;
        end
        if (ARBURST_S == BURST_WRAP) begin
`ifdef AXI_WRAP_BURST_EN
            if (!((ARLEN_S == 4'd1) || (ARLEN_S == 4'd3) ||
                  (ARLEN_S == 4'd7) || (ARLEN_S == 4'd15))) begin
                req_err_d = 1'b1;
            end
`else
            req_err_d = 1'b1;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Address of the following beat. INCR relies on natural 32-bit overflow
    // so 0xFFFFFFFC rolls over to 0x0.
    // -----------------------------------------------------------------------
`ifdef AXI_WRAP_BURST_EN
    logic [31:0] wrap_mask;
    // Covers the byte offset within the wrap window (len+1 beats of 4 bytes).
    assign wrap_mask = {26'd0, len_q, 2'b11};
`endif

    always_comb begin
        cur_addr_d = cur_addr_q;
        case (burst_q)
            BURST_FIXED: cur_addr_d = cur_addr_q;
            BURST_INCR:  cur_addr_d = cur_addr_q + 32'd4;
`ifdef AXI_WRAP_BURST_EN
            BURST_WRAP:  cur_addr_d = (cur_addr_q & ~wrap_mask) |
                                      ((cur_addr_q + 32'd4) & wrap_mask);
`endif
            default:     cur_addr_d = cur_addr_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs.
    // A served beat takes FETCH (drive SRAM), CAPTURE (SRAM data arrives) and
    // RESP (present on R). Error beats skip the SRAM and are issued straight
    // from RESP, one per accepted beat.
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            rid_q      <= 8'd0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_addr_q <= '0;
            cur_addr_q <= 32'd0;
            len_q      <= 4'd0;
            burst_q    <= BURST_FIXED;
            beat_cnt_q <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // ARREADY rises the cycle after reset release or burst end.
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                    mem_cs_q  <= 1'b0;
                    if (ARVALID_S && arready_q) begin
                        arready_q  <= 1'b0;
                        rid_q      <= ARID_S;
                        cur_addr_q <= ARADDR_S;
                        len_q      <= ARLEN_S;
                        burst_q    <= ARBURST_S;
                        beat_cnt_q <= 4'd0;
                        if (req_err_d) begin
                            err_q    <= 1'b1;
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                            rresp_q  <= RESP_SLVERR;
                            rlast_q  <= (ARLEN_S == 4'd0);
                            state_q  <= RESP;
                        end else begin
                            err_q      <= 1'b0;
                            mem_cs_q   <= 1'b1;
                            mem_addr_q <= ARADDR_S[MEM_AW+1:2];
                            state_q    <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    // The SRAM samples cs/addr at the end of this cycle.
                    mem_cs_q <= 1'b0;
                    state_q  <= CAPTURE;
                end

                CAPTURE: begin
                    rdata_q  <= mem_rdata;
                    rvalid_q <= 1'b1;
                    rresp_q  <= RESP_OKAY;
                    rlast_q  <= (beat_cnt_q == len_q);
                    state_q  <= RESP;
                end

                RESP: begin
                    // Without RREADY nothing changes, so the beat stays stable.
                    if (RREADY_S) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            err_q     <= 1'b0;
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 4'd1;
                            cur_addr_q <= cur_addr_d;
                            if (err_q) begin
                                // Next SLVERR beat follows immediately.
                                rlast_q <= ((beat_cnt_q + 4'd1) == len_q);
                            end else begin
                                rvalid_q   <= 1'b0;
                                mem_cs_q   <= 1'b1;
                                mem_addr_q <= cur_addr_d[MEM_AW+1:2];
                                state_q    <= FETCH;
                            end
                        end
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    mem_cs_q <= 1'b0;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ARREADY_S = arready_q;
    assign RID_S     = rid_q;
    assign RDATA_S   = rdata_q;
    assign RRESP_S   = rresp_q;
    assign RLAST_S   = rlast_q;
    assign RVALID_S  = rvalid_q;
    assign mem_cs    = mem_cs_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_axi_sram_read_responder.sv
// ---------------------------------------------------------------------------
// Testbench for axi_sram_read_responder.
// Directed cases followed by randomized read bursts. Expected beats are
// derived from the AXI burst rules (beat addresses by arithmetic, SRAM data
// from a bench-owned memory array) and compared beat by beat.
// ---------------------------------------------------------------------------
module tb_axi_sram_read_responder;

    localparam int MEM_AW = 14;
    localparam int DATA_W = 32;
`ifdef AXI_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    // A served beat shows RVALID on the third cycle after the accepting edge.
    localparam int LAT_OKAY = 2;
    localparam int LAT_ERR  = 0;
    localparam int MAX_WAIT = 20;

    logic              ACLK;
    logic              ARESETn;
    logic [7:0]        ARID_S;
    logic [31:0]       ARADDR_S;
    logic [3:0]        ARLEN_S;
    logic [2:0]        ARSIZE_S;
    logic [1:0]        ARBURST_S;
    logic              ARVALID_S;
    logic              ARREADY_S;
    logic [7:0]        RID_S;
    logic [DATA_W-1:0] RDATA_S;
    logic [1:0]        RRESP_S;
    logic              RLAST_S;
    logic              RVALID_S;
    logic              RREADY_S;
    logic              mem_cs;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;
    int txn_cnt = 0;

    logic [DATA_W-1:0] sram [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0] cs_q[$];

    axi_sram_read_responder #(.MEM_AW(MEM_AW), .DATA_W(DATA_W)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ARID_S    (ARID_S),
        .ARADDR_S  (ARADDR_S),
        .ARLEN_S   (ARLEN_S),
        .ARSIZE_S  (ARSIZE_S),
        .ARBURST_S (ARBURST_S),
        .ARVALID_S (ARVALID_S),
        .ARREADY_S (ARREADY_S),
        .RID_S     (RID_S),
        .RDATA_S   (RDATA_S),
        .RRESP_S   (RRESP_S),
        .RLAST_S   (RLAST_S),
        .RVALID_S  (RVALID_S),
        .RREADY_S  (RREADY_S),
        .mem_cs    (mem_cs),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Synchronous SRAM: data valid only the cycle after a select, junk otherwise.
    always @(posedge ACLK) begin
        if (mem_cs) mem_rdata <= sram[mem_addr];
        else        mem_rdata <= $urandom();
    end

    // Record every SRAM access (each select lasts exactly one cycle).
    always @(negedge ACLK) begin
        if (mem_cs) cs_q.push_back(mem_addr);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_illegal(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [3:0] len);
        int n;
        n = int'(len) + 1;
        if (size != 3'd2) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10) return !(WRAP_EN && n > 1 && ((n & (n - 1)) == 0));
        return 1'b0;
    endfunction

    // Byte address of beat b according to the burst type.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [3:0] len,
                                              input logic [1:0] burst, input int b);
        logic [31:0] bytes;
        logic [31:0] base;
        case (burst)
            2'b00:   return start;
            2'b01:   return start + 32'(4 * b);
            default: begin
                bytes = 32'(4 * (int'(len) + 1));
                base  = (start / bytes) * bytes;
                return base + (((start - base) + 32'(4 * b)) % bytes);
            end
        endcase
    endfunction

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall0, input bit rand_stall, input int abort_beat);
        bit                err;
        int                w;
        int                lat;
        int                stall;
        logic [31:0]       a;
        logic [DATA_W-1:0] exp_d;
        logic [MEM_AW-1:0] exp_w[$];

        err = model_illegal(size, burst, len);
        txn_cnt++;
        $display("txn %0d: id=%02h addr=%08h len=%0d size=%0d burst=%0d expect %s",
                 txn_cnt, id, addr, len, size, burst, err ? "SLVERR" : "OKAY");
        cs_q.delete();

        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = size; ARBURST_S = burst;
        ARVALID_S = 1'b1;
        w = 0;
        while (!ARREADY_S && w < MAX_WAIT) begin
            @(negedge ACLK);
            w++;
        end
        check_val("arready_wait", 64'(w < MAX_WAIT), 64'd1);
        if (w >= MAX_WAIT) begin
            ARVALID_S = 1'b0;
            return;
        end
        @(negedge ACLK);
        ARVALID_S = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            a     = beat_addr(addr, len, burst, b);
            exp_d = err ? '0 : sram[a[MEM_AW+1:2]];
            if (!err) exp_w.push_back(a[MEM_AW+1:2]);
            lat = 0;
            while (!RVALID_S && lat < MAX_WAIT) begin
                @(negedge ACLK);
                lat++;
            end
            check_val("rvalid_latency", 64'(lat), 64'(err ? LAT_ERR : LAT_OKAY));
            if (!RVALID_S) return;
            check_val("rdata", 64'(RDATA_S), 64'(exp_d));
            check_val("rid", 64'(RID_S), 64'(id));
            check_val("rresp", 64'(RRESP_S), err ? 64'd2 : 64'd0);
            check_val("rlast", 64'(RLAST_S), 64'(b == int'(len)));
            check_val("arready_busy", 64'(ARREADY_S), 64'd0);
            if (b == abort_beat) return;

            if (b == 0 && stall0 >= 0) stall = stall0;
            else if (rand_stall)       stall = int'($urandom_range(0, 2));
            else                       stall = 0;
            RREADY_S = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge ACLK);
                check_val("stall_rvalid", 64'(RVALID_S), 64'd1);
                check_val("stall_rdata", 64'(RDATA_S), 64'(exp_d));
                check_val("stall_rid", 64'(RID_S), 64'(id));
                check_val("stall_rlast", 64'(RLAST_S), 64'(b == int'(len)));
                check_val("stall_mem_cs", 64'(mem_cs), 64'd0);
            end
            RREADY_S = 1'b1;
            @(negedge ACLK);
            RREADY_S = 1'b0;
        end

        check_val("end_rvalid", 64'(RVALID_S), 64'd0);
        check_val("end_arready", 64'(ARREADY_S), 64'd1);
        check_val("mem_cs_count", 64'(cs_q.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < cs_q.size(); i++) begin
            check_val("mem_addr", 64'(cs_q[i]), 64'(exp_w[i]));
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_arready", 64'(ARREADY_S), 64'd0);
        check_val("rst_rvalid", 64'(RVALID_S), 64'd0);
        check_val("rst_rlast", 64'(RLAST_S), 64'd0);
        check_val("rst_rid", 64'(RID_S), 64'd0);
        check_val("rst_rdata", 64'(RDATA_S), 64'd0);
        check_val("rst_rresp", 64'(RRESP_S), 64'd0);
        check_val("rst_mem_cs", 64'(mem_cs), 64'd0);
        check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rsize;
        for (int i = 0; i < (1 << MEM_AW); i++) sram[i] = $urandom();
        ARESETn = 1'b0; ARVALID_S = 1'b0; RREADY_S = 1'b0;
        ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0; ARBURST_S = '0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs();
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_val("arready_after_reset", 64'(ARREADY_S), 64'd1);

        // Single read
        sram[4] = 32'hDEADBEEF;
        do_read(8'h13, 32'h10, 4'd0, 3'd2, 2'b01, 0, 1'b0, -1);
        // INCR burst of four
        sram[14'h40] = 32'hAAAA0001; sram[14'h41] = 32'hBBBB0002;
        sram[14'h42] = 32'hCCCC0003; sram[14'h43] = 32'hDDDD0004;
        do_read(8'h21, 32'h100, 4'd3, 3'd2, 2'b01, 0, 1'b0, -1);
        // Backpressure: five stalled cycles on beat 0
        do_read(8'h35, 32'h200, 4'd1, 3'd2, 2'b01, 5, 1'b0, -1);
        // Illegal size: three back-to-back SLVERR beats
        do_read(8'h44, 32'h300, 4'd2, 3'd0, 2'b01, 0, 1'b0, -1);
        // WRAP: served or SLVERR depending on the build
        do_read(8'h55, 32'h38, 4'd3, 3'd2, 2'b10, 0, 1'b1, -1);
        // WRAP with a non power-of-two length is always SLVERR
        do_read(8'h56, 32'h38, 4'd2, 3'd2, 2'b10, 0, 1'b0, -1);
        // FIXED burst
        do_read(8'h66, 32'h80, 4'd3, 3'd2, 2'b00, 1, 1'b1, -1);
        // INCR crossing the top of the address space
        do_read(8'h67, 32'hFFFFFFF8, 4'd3, 3'd2, 2'b01, 0, 1'b1, -1);
        // Reserved burst type
        do_read(8'h68, 32'h40, 4'd1, 3'd2, 2'b11, 2, 1'b0, -1);

        // Reset in the middle of beat 2 of an eight-beat burst
        do_read(8'h77, 32'h400, 4'd7, 3'd2, 2'b01, 0, 1'b0, 2);
        ARESETn = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_val("arready_after_abort", 64'(ARREADY_S), 64'd1);
        check_val("rvalid_after_abort", 64'(RVALID_S), 64'd0);
        do_read(8'h78, 32'h20, 4'd0, 3'd2, 2'b01, 0, 1'b0, -1);

        // Randomized bursts
        for (int t = 0; t < 60; t++) begin
            rsize = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            do_read(8'($urandom()), $urandom(), 4'($urandom_range(0, 15)), rsize,
                    2'($urandom_range(0, 3)), -1, 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
